// File: rtl/decode_stage.sv
// Instruction-decode stage: 32x32 register file, opcode/funct decode,
// immediate extension, load-use hazard detection and an ID/EX register
// with a valid/ready handshake. Accepting an illegal opcode halts the stage
// until reset.
// Optional: define DECODE_BYPASS_EN to forward a same-cycle writeback into
// the operands of the instruction being accepted.
module decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 4,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_dest,
  output logic [2:0]        out_alu_op,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              illegal
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e r_state, w_state_next;

  logic [DATA_W-1:0] r_rf [NREGS];

  logic              r_valid, r_reg_write, r_mem_read, r_mem_write, r_branch, r_illegal;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rs_val, r_rt_val, r_imm;
  logic [4:0]        r_dest;
  logic [2:0]        r_alu_op;

  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm16;
  logic        w_unused_shamt;

  assign w_opcode       = in_instr[31:26];
  assign w_rs           = in_instr[25:21];
  assign w_rt           = in_instr[20:16];
  assign w_rd           = in_instr[15:11];
  assign w_funct        = in_instr[5:0];
  assign w_imm16        = in_instr[15:0];
  assign w_unused_shamt = ^in_instr[10:6];

  logic              w_legal, w_sext, w_uses_rt;
  logic              w_reg_write, w_mem_read, w_mem_write, w_branch;
  logic [2:0]        w_alu_op;
  logic [4:0]        w_dest;
  logic [DATA_W-1:0] w_imm;

  // Decode opcode/funct into control bits
  always_comb begin
    w_legal     = 1'b1;
    w_sext      = 1'b1;
    w_uses_rt   = 1'b0;
    w_alu_op    = 3'd0;
    w_dest      = 5'd0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_uses_rt   = 1'b1;
        w_dest      = w_rd;
        w_reg_write = 1'b1;
        case (w_funct)
          6'h20:   w_alu_op = 3'd0;
          6'h22:   w_alu_op = 3'd1;
          6'h24:   w_alu_op = 3'd2;
          6'h25:   w_alu_op = 3'd3;
          6'h2A:   w_alu_op = 3'd4;
          default: w_legal  = 1'b0;
        endcase
      end
      6'h08: begin
        w_dest      = w_rt;
        w_reg_write = 1'b1;
      end
      6'h0C: begin
        w_alu_op    = 3'd2;
        w_sext      = 1'b0;
        w_dest      = w_rt;
        w_reg_write = 1'b1;
      end
      6'h0D: begin
        w_alu_op    = 3'd3;
        w_sext      = 1'b0;
        w_dest      = w_rt;
        w_reg_write = 1'b1;
      end
      6'h23: begin
        w_dest      = w_rt;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
      end
      6'h2B: begin
        w_uses_rt   = 1'b1;
        w_mem_write = 1'b1;
      end
      6'h04: begin
        w_uses_rt = 1'b1;
        w_alu_op  = 3'd1;
        w_branch  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // A write to r0 is a no-op, so never advertise it downstream.
    if (w_dest == 5'd0) w_reg_write = 1'b0;
  end

  assign w_imm = w_sext ? {{(DATA_W-16){w_imm16[15]}}, w_imm16}
                        : {{(DATA_W-16){1'b0}}, w_imm16};

  logic [DATA_W-1:0] w_rs_rf, w_rt_rf, w_rs_val, w_rt_val;

  assign w_rs_rf = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rt_rf = (w_rt == 5'd0) ? '0 : r_rf[w_rt];

`ifdef DECODE_BYPASS_EN
  assign w_rs_val = (wb_en && wb_addr != 5'd0 && wb_addr == w_rs) ? wb_data : w_rs_rf;
  assign w_rt_val = (wb_en && wb_addr != 5'd0 && wb_addr == w_rt) ? wb_data : w_rt_rf;
`else
  assign w_rs_val = w_rs_rf;
  assign w_rt_val = w_rt_rf;
`endif

  logic w_hazard, w_accept;

  // A load in ID/EX whose result the incoming instruction needs forces a bubble.
  assign w_hazard = r_valid && r_mem_read && (r_dest != 5'd0) &&
                    ((w_rs == r_dest) || (w_uses_rt && (w_rt == r_dest)));

  assign in_ready = rst_n && (r_state == StRun) && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Next-state: leave RUN for good once an illegal opcode is accepted
  always_comb begin
    w_state_next = r_state;
    if (r_state == StRun && w_accept && !w_legal) w_state_next = StHalt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StRun;
    else        r_state <= w_state_next;
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_imm       <= '0;
      r_dest      <= '0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b1;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= in_pc;
      r_rs_val    <= w_rs_val;
      r_rt_val    <= w_rt_val;
      r_imm       <= w_imm;
      r_dest      <= w_dest;
      r_alu_op    <= w_alu_op;
      r_reg_write <= w_reg_write;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_branch    <= w_branch;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rs_val    = r_rs_val;
  assign out_rt_val    = r_rt_val;
  assign out_imm       = r_imm;
  assign out_dest      = r_dest;
  assign out_alu_op    = r_alu_op;
  assign out_reg_write = r_reg_write;
  assign out_mem_read  = r_mem_read;
  assign out_mem_write = r_mem_write;
  assign out_branch    = r_branch;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of decode vectors fed through a
// scoreboard, plus hand sequences for reset, load-use bubble, back-pressure,
// illegal halt and same-cycle writeback.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_pc;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [4:0]  out_dest;
  logic [2:0]  out_alu_op;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, illegal;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_imm(out_imm),
    .out_dest(out_dest), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pc;
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic        rw, mr, mw, br;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t cur_exp;
  bit   cur_push;
  logic s_in_ready, s_out_valid;
  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t actual();
    return exp_t'{pc: out_pc, rs: out_rs_val, rt: out_rt_val, imm: out_imm, dest: out_dest,
                  op: out_alu_op, rw: out_reg_write, mr: out_mem_read, mw: out_mem_write,
                  br: out_branch};
  endfunction

  // One clock: sample after inputs settle, pop consumed output, push accepted input.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 128'(actual()), 128'(0) + 1);
      end else begin
        e = sb.pop_front();
        check("sb_output", 128'(actual()), 128'(e));
      end
    end
    if (acc && cur_push) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr, input exp_t e);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = e.pc; cur_exp = e; cur_push = 1'b1;
    while (!acc && n < 8) begin
      cycle(acc);
      n++;
    end
    check("accept", 128'(acc), 128'(1));
    in_valid = 1'b0; cur_push = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  exp_t e_add3, e_sub10, e_lw5, e_add6, e_byp;
  bit   acc;

  initial begin
    //                pc     rs         rt         imm        dest  op rw mr mw br
    vecs[0]  = '{32'h00221820, '{4'd0,  32'd5, 32'd7, 32'h00001820, 5'd3,  3'd0, 1, 0, 0, 0}};
    vecs[1]  = '{32'h2004FFFF, '{4'd1,  32'd0, 32'd0, 32'hFFFFFFFF, 5'd4,  3'd0, 1, 0, 0, 0}};
    vecs[2]  = '{32'h3404FFFF, '{4'd2,  32'd0, 32'd0, 32'h0000FFFF, 5'd4,  3'd3, 1, 0, 0, 0}};
    vecs[3]  = '{32'h30498001, '{4'd3,  32'd7, 32'd0, 32'h00008001, 5'd9,  3'd2, 1, 0, 0, 0}};
    vecs[4]  = '{32'h00415022, '{4'd4,  32'd7, 32'd5, 32'h00005022, 5'd10, 3'd1, 1, 0, 0, 0}};
    vecs[5]  = '{32'h00225824, '{4'd5,  32'd5, 32'd7, 32'h00005824, 5'd11, 3'd2, 1, 0, 0, 0}};
    vecs[6]  = '{32'h00226025, '{4'd6,  32'd5, 32'd7, 32'h00006025, 5'd12, 3'd3, 1, 0, 0, 0}};
    vecs[7]  = '{32'h0022682A, '{4'd7,  32'd5, 32'd7, 32'h0000682A, 5'd13, 3'd4, 1, 0, 0, 0}};
    vecs[8]  = '{32'hAC22FFFC, '{4'd8,  32'd5, 32'd7, 32'hFFFFFFFC, 5'd0,  3'd0, 0, 0, 1, 0}};
    vecs[9]  = '{32'h10220003, '{4'd9,  32'd5, 32'd7, 32'h00000003, 5'd0,  3'd1, 0, 0, 0, 1}};
    vecs[10] = '{32'h00220020, '{4'd10, 32'd5, 32'd7, 32'h00000020, 5'd0,  3'd0, 0, 0, 0, 0}};
    vecs[11] = '{32'h8C4E0008, '{4'd11, 32'd7, 32'd0, 32'h00000008, 5'd14, 3'd0, 1, 1, 0, 0}};
    e_add3  = '{4'd1, 32'd5, 32'd7, 32'h00001820, 5'd3, 3'd0, 1, 0, 0, 0};
    e_sub10 = '{4'd2, 32'd7, 32'd5, 32'h00005022, 5'd10, 3'd1, 1, 0, 0, 0};
    e_lw5   = '{4'd12, 32'd5, 32'd0, 32'h00000000, 5'd5, 3'd0, 1, 1, 0, 0};
    e_add6  = '{4'd13, 32'd0, 32'd0, 32'h00003020, 5'd6, 3'd0, 1, 0, 0, 0};

    // Reset held two cycles with a valid instruction offered
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 4'd0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; cur_push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_in_ready", 128'(in_ready), 128'(0));
      check("reset_out_valid", 128'(out_valid), 128'(0));
    end
    check("reset_outputs", 128'(actual()), 128'(0));
    check("reset_illegal", 128'(illegal), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Program r1=5, r2=7 through the writeback port
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; cycle(acc);
    wb_addr = 5'd2; wb_data = 32'd7; cycle(acc);
    wb_en = 1'b0;

    // Decode table, back to back
    for (int i = 0; i < 12; i++) issue(vecs[i].instr, vecs[i].exp);

    // Load-use: lw r5,0(r1) then add r6,r5,r5 -> exactly one bubble
    issue(32'h8C250000, e_lw5);
    in_valid = 1'b1; in_instr = 32'h00A53020; in_pc = 4'd13; cur_exp = e_add6; cur_push = 1'b1;
    cycle(acc);
    check("hazard_in_ready_low", 128'(s_in_ready), 128'(0));
    cycle(acc);
    check("bubble_out_valid", 128'(s_out_valid), 128'(0));
    check("after_bubble_in_ready", 128'(s_in_ready), 128'(1));
    check("after_bubble_accept", 128'(acc), 128'(1));
    cur_push = 1'b0;
    drain(2);

    // Back-pressure: hold out_ready low 3 cycles with the next instruction offered
    issue(32'h00221820, e_add3);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00415022; in_pc = 4'd2; cur_exp = e_sub10; cur_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check("stall_in_ready", 128'(s_in_ready), 128'(0));
      check("stall_out_held", 128'(actual()), 128'(e_add3));
      check("stall_out_valid", 128'(out_valid), 128'(1));
    end
    out_ready = 1'b1;
    cycle(acc);
    check("release_accept", 128'(acc), 128'(1));
    cur_push = 1'b0;
    drain(3);
    check("sb_empty_after_stall", 128'(sb.size()), 128'(0));

    // Illegal opcode 0x3F: not issued, halts until reset
    in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 4'd15; cur_push = 1'b0;
    cycle(acc);
    check("illegal_accept", 128'(acc), 128'(1));
    in_instr = 32'h00221820;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check("halt_in_ready", 128'(s_in_ready), 128'(0));
      check("halt_out_valid", 128'(s_out_valid), 128'(0));
      check("halt_illegal", 128'(illegal), 128'(1));
    end
    rst_n = 1'b0;
    cycle(acc);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("post_reset_illegal", 128'(illegal), 128'(0));
    check("post_reset_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    // Writeback r7=9 in the same cycle as accepting add r8,r7,r0
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd9;
`ifdef DECODE_BYPASS_EN
    e_byp = '{4'd3, 32'd9, 32'd0, 32'h00004020, 5'd8, 3'd0, 1, 0, 0, 0};
`else
    e_byp = '{4'd3, 32'd0, 32'd0, 32'h00004020, 5'd8, 3'd0, 1, 0, 0, 0};
`endif
    issue(32'h00E04020, e_byp);
    wb_en = 1'b0;
    drain(1);
    e_byp.rs = 32'd9;
    issue(32'h00E04020, e_byp);
    drain(2);
    check("sb_empty_end", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage directly downstream of fetch; consumes the 32-bit instruction word and its 4-bit pc.
- Holds the 32x32 architectural register file; decodes opcode/funct into control bits, reads rs/rt, extends the immediate.
- Registers everything into the ID/EX pipeline register with a valid/ready handshake.
- Detects load-use hazards and halts permanently on an illegal opcode.

Parameters:
- DATA_W, 32, register and operand width
- PC_W, 4, width of the pc carried alongside the instruction
- NREGS, 32, register-file depth; register address width is fixed at 5

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  decode accepts in_instr this cycle
- in_instr  input  32  instruction word
- in_pc  input  PC_W  pc of in_instr
- wb_en  input  1  writeback write enable
- wb_addr  input  5  writeback register
- wb_data  input  DATA_W  writeback value
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  execute consumes the ID/EX contents
- out_pc  output  PC_W  pc of the decoded instruction
- out_rs_val  output  DATA_W  rs operand
- out_rt_val  output  DATA_W  rt operand
- out_imm  output  DATA_W  extended immediate
- out_dest  output  5  destination register
- out_alu_op  output  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- out_reg_write  output  1  instruction writes out_dest
- out_mem_read  output  1  lw
- out_mem_write  output  1  sw
- out_branch  output  1  beq
- illegal  output  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst_n=0 at a clk edge): all out_* = 0, illegal = 0, state = RUN, all registers cleared to 0. Reset wins over every other event, including a pending handshake.
- Register file:
  - 32 entries; r0 reads 0 always.
  - Writes when wb_en=1 and wb_addr!=0; the write lands at the clk edge.
- Decode table (opcode = instr[31:26]):
  - 0x00 R-type: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; dest = rd; reg_write = 1.
  - 0x08 addi: ADD, imm sign-extended, dest = rt.
  - 0x0C andi / 0x0D ori: AND / OR, imm zero-extended, dest = rt.
  - 0x23 lw: ADD, sign-extended, dest = rt, mem_read = 1.
  - 0x2B sw: ADD, sign-extended, mem_write = 1, reg_write = 0, dest = 0.
  - 0x04 beq: SUB, sign-extended, branch = 1, reg_write = 0, dest = 0.
  - Any other opcode, or any other funct under 0x00, is illegal.
  - reg_write is forced to 0 whenever dest = 0.
- Hazard: asserted when out_valid=1, out_mem_read=1, out_dest!=0, and in_instr's rs == out_dest, or its rt == out_dest for R-type/sw/beq.
- in_ready = (state==RUN) && !hazard && (!out_valid || out_ready).
- ID/EX register update on each clk edge:
  - Accept (in_valid && in_ready): load the decoded fields; out_valid = 1.
  - Else if out_ready: out_valid = 0. This inserts the one-cycle load-use bubble.
  - Else: hold all outputs.
- Latency: an instruction accepted at edge N is visible on out_* after edge N.
- State machine:
  - RUN -> HALT when an illegal instruction is accepted. That cycle sets illegal = 1 and loads out_valid = 0 (nothing is issued).
  - HALT: in_ready = 0; out_valid drains normally. Exits only by reset.
- Simultaneous writeback and read of the same register: see the optional feature.
- Out-of-range results are not possible; the immediate is always exactly 16->32 extended.

Optional Feature:
- Macro: DECODE_BYPASS_EN
- Defined: if wb_en=1 and wb_addr!=0 equals rs (or rt) of the instruction being accepted, wb_data is forwarded into out_rs_val (or out_rt_val) in that same cycle.
- Undefined: the register file returns the pre-write value. The bench must insert a 1-cycle gap for a correct dependent read.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in_valid=1 -> out_valid=0, in_ready=0 during reset, illegal=0, all out_* = 0.
- Program wb r1=5, r2=7, then present add r3,r1,r2 (0x00221820) with out_ready=1 -> one cycle later out_valid=1, out_rs_val=5, out_rt_val=7, out_dest=3, out_alu_op=0, out_reg_write=1.
- addi r4,r0,-1 (0x2004FFFF) -> out_imm=0xFFFFFFFF. ori r4,r0,0xFFFF (0x3404FFFF) -> out_imm=0x0000FFFF.
- lw r5,0(r1) followed by add r6,r5,r5 with out_ready=1 -> in_ready=0 for exactly one cycle, one bubble (out_valid=0), then the add issues.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; the first instruction is neither lost nor duplicated after release.
- Opcode 0x3F -> illegal=1, that instruction is not issued, in_ready stays 0 until rst_n=0. With DECODE_BYPASS_EN defined, wb r7=9 in the same cycle as accepting add r8,r7,r0 -> out_rs_val=9.
